peripheral_ahb3_slave_mem: RTL and testbench

// - Synthesizable AHB3-Lite slave memory; the downstream consumer of AHB3 master transfers (SINGLE, INCR, INCRx, WRAPx).
// - Word-organised RAM with byte-lane writes, programmable wait states, two-cycle ERROR response.
// - Serves as the target memory for DMA/GPIO bench environments.

---
 rtl/peripheral_ahb3_pkg.sv | 25 ++
 rtl/peripheral_ahb3_slave_mem_if.sv | 27 ++
 rtl/peripheral_ahb3_lane_mask.sv | 15 +
 rtl/peripheral_ahb3_slave_mem.sv | 84 ++++++++
 tb/tb_peripheral_ahb3_slave_mem.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_ahb3_pkg.sv
// peripheral_ahb3_pkg: shared AHB3-Lite encodings for transfer type, size, burst and response
package peripheral_ahb3_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_B8      = 3'b000;
  localparam logic [2:0] HSIZE_B16     = 3'b001;
  localparam logic [2:0] HSIZE_B32     = 3'b010;
  localparam logic [2:0] HSIZE_B64     = 3'b011;
  localparam logic [2:0] HSIZE_B128    = 3'b100;
  localparam logic [2:0] HSIZE_B256    = 3'b101;
  localparam logic [2:0] HSIZE_B512    = 3'b110;
  localparam logic [2:0] HSIZE_B1024   = 3'b111;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
endpackage

// File: rtl/peripheral_ahb3_slave_mem_if.sv
// peripheral_ahb3_slave_mem_if: AHB3-Lite bus bundle as seen between a master/interconnect and one slave
interface peripheral_ahb3_slave_mem_if #(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/peripheral_ahb3_lane_mask.sv
// peripheral_ahb3_lane_mask: little-endian byte-lane enables and alignment flag for one AHB transfer
module peripheral_ahb3_lane_mask #(
  parameter int BYTES = 4,
  parameter int LSB_W = 2
) (
  input  logic [2:0]       hsize_i,
  input  logic [LSB_W-1:0] addr_i,
  output logic [BYTES-1:0] be_o,
  output logic             misalign_o
);
  always_comb begin
    for (int i = 0; i < BYTES; i++) be_o[i] = i >= int'(addr_i) && i < int'(addr_i) + (1 << hsize_i);
    misalign_o = (int'(addr_i) & ((1 << hsize_i) - 1)) != 0;
  end
endmodule

// File: rtl/peripheral_ahb3_slave_mem.sv
// peripheral_ahb3_slave_mem: AHB3-Lite word RAM slave with byte lanes, programmable wait states
// and a two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module peripheral_ahb3_slave_mem
  import peripheral_ahb3_pkg::*;
#(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic HRESETn,
  input logic HCLK,
  peripheral_ahb3_slave_mem_if.slave ahb
);
  localparam int BYTES = HDATA_SIZE / 8;
  localparam int ALIGN = $clog2(BYTES);
  localparam int LSB_W = ALIGN > 0 ? ALIGN : 1;
  localparam int IDX_W = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BYTES-1:0]      be_q, be_d, be;
  logic                  write_q, write_d;
  logic                  accept, err, misalign;
  logic [LSB_W-1:0]      lsb;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
  logic                  unused_ok;
  assign unused_ok = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK};
  assign lsb = ALIGN > 0 ? ahb.HADDR[LSB_W-1:0] : '0;
  peripheral_ahb3_lane_mask #(.BYTES(BYTES), .LSB_W(LSB_W)) u_lane_mask (
    .hsize_i   (ahb.HSIZE),
    .addr_i    (lsb),
    .be_o      (be),
    .misalign_o(misalign)
  );
  assign accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign err = (ahb.HADDR >> ALIGN) >= HADDR_SIZE'(MEM_DEPTH) || int'(ahb.HSIZE) > ALIGN || misalign;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      write_q <= write_d;
    end
  // WAIT and ERR1 hold HREADYOUT low, so no new address can be accepted there
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    if (state_q == ST_WAIT) begin
      state_d = cnt_q == 4'd0 ? ST_DATA : ST_WAIT;
      cnt_d   = cnt_q - 4'd1;
    end else if (state_q == ST_ERR1) state_d = ST_ERR2;
    else begin
      state_d = !accept ? ST_IDLE : err ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_DATA;
      cnt_d   = WAIT_LOAD;
      if (accept) begin
        idx_d   = ahb.HADDR[ALIGN +: IDX_W];
        be_d    = be;
        write_d = ahb.HWRITE & !err;
      end
    end
  end
  always_comb begin
    ahb.HREADYOUT = !(state_q inside {ST_WAIT, ST_ERR1});
    ahb.HRESP     = state_q inside {ST_ERR1, ST_ERR2} ? HRESP_ERROR : HRESP_OKAY;
    ahb.HRDATA    = state_q inside {ST_WAIT, ST_DATA} && !write_q ? mem[idx_q] : '0;
  end
  // commit at the end of the write data phase so a following read beat already sees it
  always_ff @(posedge HCLK)
    if (state_q == ST_DATA && write_q)
      for (int i = 0; i < BYTES; i++) if (be_q[i]) mem[idx_q][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
endmodule

// File: tb/tb_peripheral_ahb3_slave_mem.sv
// tb_peripheral_ahb3_slave_mem: pipelined AHB master driver against a zero-wait and a two-wait slave
module tb_peripheral_ahb3_slave_mem;
  import peripheral_ahb3_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst0_n, rst2_n, h_sel, h_write;
  bit          cur;
  logic [15:0] h_addr;
  logic [31:0] h_wdata;
  logic [2:0]  h_size, h_burst;
  logic [1:0]  h_trans;
  logic        cur_ready, cur_resp;
  logic [31:0] cur_rdata;
  int n_checks = 0, n_fail = 0;
  peripheral_ahb3_slave_mem_if bus0 ();
  peripheral_ahb3_slave_mem_if bus2 ();
  assign bus0.HSEL = h_sel & !cur;
  assign bus0.HADDR = h_addr;
  assign bus0.HWDATA = h_wdata;
  assign bus0.HWRITE = h_write;
  assign bus0.HSIZE = h_size;
  assign bus0.HBURST = h_burst;
  assign bus0.HPROT = 4'h3;
  assign bus0.HTRANS = h_trans;
  assign bus0.HMASTLOCK = 1'b0;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus2.HSEL = h_sel & cur;
  assign bus2.HADDR = h_addr;
  assign bus2.HWDATA = h_wdata;
  assign bus2.HWRITE = h_write;
  assign bus2.HSIZE = h_size;
  assign bus2.HBURST = h_burst;
  assign bus2.HPROT = 4'h3;
  assign bus2.HTRANS = h_trans;
  assign bus2.HMASTLOCK = 1'b0;
  assign bus2.HREADY = bus2.HREADYOUT;
  assign cur_ready = cur ? bus2.HREADYOUT : bus0.HREADYOUT;
  assign cur_resp  = cur ? bus2.HRESP : bus0.HRESP;
  assign cur_rdata = cur ? bus2.HRDATA : bus0.HRDATA;
  peripheral_ahb3_slave_mem #(.WAIT_STATES(0)) dut0 (.HRESETn(rst0_n), .HCLK(clk), .ahb(bus0));
  peripheral_ahb3_slave_mem #(.WAIT_STATES(2)) dut2 (.HRESETn(rst2_n), .HCLK(clk), .ahb(bus2));
  logic [15:0] b_addr [16];
  logic        b_wr [16];
  logic [2:0]  b_size [16];
  logic [1:0]  b_trans [16];
  logic [31:0] b_wdata [16];
  logic [31:0] r_rdata [16];
  logic        r_resp [16];
  logic        r_done [16];
  int          r_low [16];
  int          n_beats, run_cycles, run_low;
  logic [7:0]  mb [256];
  task automatic set_beat(input int i, input logic [15:0] a, input logic w, input logic [2:0] s, input logic [1:0] t, input logic [31:0] d);
    b_addr[i] = a; b_wr[i] = w; b_size[i] = s; b_trans[i] = t; b_wdata[i] = d;
  endtask
  task automatic run_beats();
    int a = 0, d = -1, cyc = 0;
    bit abort = 0;
    logic rdy, rsp;
    logic [31:0] rd;
    run_low = 0;
    for (int i = 0; i < 16; i++) begin r_done[i] = 0; r_low[i] = 0; r_resp[i] = 0; r_rdata[i] = 0; end
    while ((a < n_beats && !abort) || d >= 0) begin
      if (cyc > 200) begin
        n_checks++; n_fail++;
        $display("FAIL run_timeout: %0d cycles without finishing, limit 200", cyc);
        break;
      end
      if (a < n_beats && !abort) begin
        h_trans = b_trans[a]; h_addr = b_addr[a]; h_write = b_wr[a]; h_size = b_size[a];
      end else h_trans = HTRANS_IDLE;
      h_wdata = d >= 0 ? b_wdata[d] : 32'h0;
      @(negedge clk);
      rdy = cur_ready; rsp = cur_resp; rd = cur_rdata; cyc++;
      if (!rdy) begin
        run_low++;
        if (d >= 0) r_low[d]++;
        if (rsp) abort = 1;
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (d >= 0) begin r_done[d] = 1; r_resp[d] = rsp; r_rdata[d] = rd; end
        if (a < n_beats && !abort) begin d = b_trans[a][1] ? a : -1; a++; end
        else d = -1;
      end
    end
    h_trans = HTRANS_IDLE;
    run_cycles = cyc;
  endtask
  function automatic bit mdl_err(input logic [15:0] a, input logic [2:0] s);
    return (int'(a) / 4) >= 256 || s > 3'd2 || (int'(a) % (1 << s)) != 0;
  endfunction
  function automatic logic [31:0] mdl_word(input logic [15:0] a);
    int w = int'(a) & 8'hFC;
    return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
  endfunction
  task automatic mdl_write(input logic [15:0] a, input logic [2:0] s, input logic [31:0] d);
    for (int k = 0; k < (1 << s); k++) mb[(int'(a) + k) & 8'hFF] = d[8*((int'(a) + k) % 4) +: 8];
  endtask
  task automatic test_reset();
    rst0_n = 0; rst2_n = 0; cur = 0; h_sel = 0; h_trans = HTRANS_IDLE; h_addr = 0;
    h_write = 0; h_size = HSIZE_B32; h_burst = HBURST_SINGLE; h_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus0.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b want 1", bus0.HREADYOUT); end
    n_checks++; if (bus0.HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_resp0: got %b want 0", bus0.HRESP); end
    n_checks++; if (bus0.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h want 0", bus0.HRDATA); end
    n_checks++; if (bus2.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_ready2: got %b want 1", bus2.HREADYOUT); end
    n_checks++; if (bus2.HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_resp2: got %b want 0", bus2.HRESP); end
    rst0_n = 1; rst2_n = 1; h_sel = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    cur = 0; h_burst = HBURST_SINGLE; n_beats = 1;
    set_beat(0, 16'h0010, 1, HSIZE_B32, HTRANS_NONSEQ, 32'hDEADBEEF);
    run_beats();
    n_checks++; if (r_resp[0] !== HRESP_OKAY) begin n_fail++; $display("FAIL single_wr_resp: got %b want 0", r_resp[0]); end
    n_checks++; if (run_low !== 0) begin n_fail++; $display("FAIL single_wr_wait: got %0d low cycles want 0", run_low); end
    set_beat(0, 16'h0010, 0, HSIZE_B32, HTRANS_NONSEQ, 32'h0);
    run_beats();
    n_checks++; if (r_rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rd_data: got %h want deadbeef", r_rdata[0]); end
    n_checks++; if (r_resp[0] !== HRESP_OKAY) begin n_fail++; $display("FAIL single_rd_resp: got %b want 0", r_resp[0]); end
    n_checks++; if (run_low !== 0 || run_cycles !== 2) begin n_fail++; $display("FAIL single_rd_timing: got %0d low %0d cycles want 0 low 2 cycles", run_low, run_cycles); end
  endtask
  task automatic test_byte_lanes();
    cur = 0; n_beats = 3;
    set_beat(0, 16'h0010, 1, HSIZE_B32, HTRANS_NONSEQ, 32'h11223344);
    set_beat(1, 16'h0013, 1, HSIZE_B8, HTRANS_NONSEQ, 32'hAA000000);
    set_beat(2, 16'h0010, 0, HSIZE_B32, HTRANS_NONSEQ, 32'h0);
    run_beats();
    n_checks++; if (r_rdata[2] !== 32'hAA223344) begin n_fail++; $display("FAIL byte_lane_rd: got %h want aa223344", r_rdata[2]); end
    n_checks++; if (run_cycles !== 4) begin n_fail++; $display("FAIL byte_lane_cycles: got %0d want 4", run_cycles); end
    n_beats = 1;
    set_beat(0, 16'h0011, 1, HSIZE_B16, HTRANS_NONSEQ, 32'hBBBBBBBB);
    run_beats();
    n_checks++; if (r_resp[0] !== HRESP_ERROR) begin n_fail++; $display("FAIL misalign_resp: got %b want 1", r_resp[0]); end
    set_beat(0, 16'h0010, 0, HSIZE_B32, HTRANS_NONSEQ, 32'h0);
    run_beats();
    n_checks++; if (r_rdata[0] !== 32'hAA223344) begin n_fail++; $display("FAIL misalign_unchanged: got %h want aa223344", r_rdata[0]); end
  endtask
  task automatic test_burst_wrap();
    logic [31:0] exp [4];
    cur = 0; n_beats = 4; h_burst = HBURST_INCR4;
    for (int i = 0; i < 4; i++) set_beat(i, 16'(16'h0020 + 4 * i), 1, HSIZE_B32, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 32'(i + 1));
    run_beats();
    h_burst = HBURST_WRAP4;
    for (int i = 0; i < 4; i++) set_beat(i, 16'(16'h0020 + ((8 + 4 * i) % 16)), 0, HSIZE_B32, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h0);
    run_beats();
    exp[0] = 3; exp[1] = 4; exp[2] = 1; exp[3] = 2;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (r_rdata[i] !== exp[i]) begin n_fail++; $display("FAIL wrap4_beat%0d: got %h want %h", i, r_rdata[i], exp[i]); end
    end
    n_checks++; if (run_cycles !== 5 || run_low !== 0) begin n_fail++; $display("FAIL wrap4_timing: got %0d cycles %0d low want 5 cycles 0 low", run_cycles, run_low); end
    h_burst = HBURST_SINGLE;
  endtask
  task automatic test_out_of_range();
    cur = 0; n_beats = 1;
    set_beat(0, 16'h0000, 1, HSIZE_B32, HTRANS_NONSEQ, 32'hCAFEF00D);
    run_beats();
    set_beat(0, 16'h0400, 1, HSIZE_B32, HTRANS_NONSEQ, 32'h12345678);
    run_beats();
    n_checks++; if (r_resp[0] !== HRESP_ERROR) begin n_fail++; $display("FAIL oor_resp: got %b want 1", r_resp[0]); end
    n_checks++; if (r_low[0] !== 1) begin n_fail++; $display("FAIL oor_err1_len: got %0d low cycles want 1", r_low[0]); end
    set_beat(0, 16'h0000, 0, HSIZE_B32, HTRANS_NONSEQ, 32'h0);
    run_beats();
    n_checks++; if (r_rdata[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL oor_unchanged: got %h want cafef00d", r_rdata[0]); end
    n_checks++; if (r_resp[0] !== HRESP_OKAY) begin n_fail++; $display("FAIL oor_next_okay: got %b want 0", r_resp[0]); end
  endtask
  task automatic test_wait_states();
    logic [31:0] exp [4];
    cur = 1; n_beats = 5; h_burst = HBURST_INCR4;
    for (int i = 0; i < 4; i++) exp[i] = $urandom;
    set_beat(0, 16'h0040, 1, HSIZE_B32, HTRANS_NONSEQ, exp[0]);
    set_beat(1, 16'h0044, 1, HSIZE_B32, HTRANS_SEQ, exp[1]);
    set_beat(2, 16'h0048, 1, HSIZE_B32, HTRANS_BUSY, 32'h0);
    set_beat(3, 16'h0048, 1, HSIZE_B32, HTRANS_SEQ, exp[2]);
    set_beat(4, 16'h004C, 1, HSIZE_B32, HTRANS_SEQ, exp[3]);
    run_beats();
    for (int i = 0; i < 5; i++) if (i != 2) begin
      n_checks++; if (r_low[i] !== 2) begin n_fail++; $display("FAIL ws_beat%0d_wait: got %0d want 2", i, r_low[i]); end
    end
    n_checks++; if (run_low !== 8) begin n_fail++; $display("FAIL ws_busy_total_wait: got %0d want 8", run_low); end
    n_beats = 4;
    for (int i = 0; i < 4; i++) set_beat(i, 16'(16'h0040 + 4 * i), 0, HSIZE_B32, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h0);
    run_beats();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (r_rdata[i] !== exp[i]) begin n_fail++; $display("FAIL ws_rd_beat%0d: got %h want %h", i, r_rdata[i], exp[i]); end
    end
    h_burst = HBURST_SINGLE;
  endtask
  task automatic test_reset_abort();
    cur = 1; n_beats = 1;
    set_beat(0, 16'h0030, 1, HSIZE_B32, HTRANS_NONSEQ, 32'h55555555);
    run_beats();
    h_trans = HTRANS_NONSEQ; h_addr = 16'h0030; h_write = 1; h_size = HSIZE_B32;
    @(posedge clk); #1;
    h_trans = HTRANS_IDLE; h_wdata = 32'h0;
    @(negedge clk);
    n_checks++; if (cur_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_wait: got ready %b want 0", cur_ready); end
    rst2_n = 0;
    #1;
    n_checks++; if (cur_ready !== 1'b1 || cur_resp !== 1'b0) begin n_fail++; $display("FAIL abort_immediate: got ready %b resp %b want 1 0", cur_ready, cur_resp); end
    @(posedge clk); #1;
    rst2_n = 1;
    @(posedge clk); #1;
    set_beat(0, 16'h0030, 0, HSIZE_B32, HTRANS_NONSEQ, 32'h0);
    run_beats();
    n_checks++; if (r_rdata[0] !== 32'h55555555) begin n_fail++; $display("FAIL abort_write_discarded: got %h want 55555555", r_rdata[0]); end
  endtask
  task automatic test_random();
    bit stopped;
    logic [31:0] exp;
    cur = 0; n_beats = 16; h_burst = HBURST_INCR16;
    for (int i = 0; i < 16; i++) begin
      set_beat(i, 16'(4 * i), 1, HSIZE_B32, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, $urandom);
      mdl_write(b_addr[i], HSIZE_B32, b_wdata[i]);
    end
    run_beats();
    n_checks++; if (run_cycles !== 17) begin n_fail++; $display("FAIL incr16_cycles: got %0d want 17", run_cycles); end
    h_burst = HBURST_SINGLE; n_beats = 4;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++) begin
        int r = $urandom_range(0, 9);
        set_beat(i, r == 0 ? 16'(16'h0400 + $urandom_range(0, 63)) : 16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                 r == 1 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)), HTRANS_NONSEQ, $urandom);
      end
      run_beats();
      stopped = 0;
      for (int i = 0; i < 4; i++) begin
        if (stopped) begin
          n_checks++; if (r_done[i] !== 1'b0) begin n_fail++; $display("FAIL rnd_abandoned c%0d b%0d: got done %b want 0", c, i, r_done[i]); end
        end else begin
          bit e = mdl_err(b_addr[i], b_size[i]);
          n_checks++; if (r_done[i] !== 1'b1 || r_resp[i] !== e) begin n_fail++; $display("FAIL rnd_resp c%0d b%0d addr %h size %0d: got done %b resp %b want 1 %b", c, i, b_addr[i], b_size[i], r_done[i], r_resp[i], e); end
          exp = e ? 32'h0 : mdl_word(b_addr[i]);
          if (e || !b_wr[i]) begin
            n_checks++; if (r_rdata[i] !== exp) begin n_fail++; $display("FAIL rnd_rdata c%0d b%0d addr %h: got %h want %h", c, i, b_addr[i], r_rdata[i], exp); end
          end
          if (!e && b_wr[i]) mdl_write(b_addr[i], b_size[i], b_wdata[i]);
          stopped = e;
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_byte_lanes();
    test_burst_wrap();
    test_out_of_range();
    test_wait_states();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
